// File: rtl/ysyx_22040088_pkg.sv
// Shared definitions for the ysyx_22040088 NPC multiply/divide unit.
//   XLEN        : datapath width
//   MDU_*       : operation class encodings driven by the control unit
//   mdu_state_t : handshake FSM states of the MDU
package ysyx_22040088_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [1:0] MDU_MUL = 2'd0;
  localparam logic [1:0] MDU_DIV = 2'd1;
  localparam logic [1:0] MDU_REM = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } mdu_state_t;

endpackage

// File: rtl/ysyx_22040088_mdu_iter.sv
// Unsigned iterative engine: one shift-add multiply step or one restoring-divide step per cycle.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : abort the current run (counter back to 0)
//   start       : load operands and iteration count
//   is_div      : 1 = divide (a / b), 0 = multiply (a * b)
//   word        : 32 iterations instead of XLEN
//   a, b        : unsigned magnitudes
//   last        : the step taken on the next edge is the final one
//   prod_next   : product after the step taken on the next edge
//   quot_next   : quotient after the step taken on the next edge
//   rem_next    : remainder after the step taken on the next edge
module ysyx_22040088_mdu_iter #(
  parameter int unsigned XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic              is_div,
  input  logic              word,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              last,
  output logic [2*XLEN-1:0] prod_next,
  output logic [XLEN-1:0]   quot_next,
  output logic [XLEN-1:0]   rem_next
);

  localparam int unsigned CntWidth = $clog2(XLEN) + 1;
  localparam int unsigned WordW    = 32;

  // MUL: acc = running product, sh = multiplicand shifted left, aux = multiplier shifted right.
  // DIV: acc = partial remainder, sh = divisor, aux = dividend shifting out / quotient shifting in.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] sh_q, sh_d;
  logic [XLEN-1:0]   aux_q, aux_d;
  logic              is_div_q;
  logic [CntWidth-1:0] cnt_q;
  logic [XLEN:0]     rshift, diff;

  always_comb begin
    acc_d  = acc_q;
    sh_d   = sh_q;
    aux_d  = aux_q;
    rshift = '0;
    diff   = '0;
    if (is_div_q) begin
      rshift = {acc_q[XLEN-1:0], aux_q[XLEN-1]};
      diff   = rshift - {1'b0, sh_q[XLEN-1:0]};
      // Borrow out of the top bit means the trial subtraction failed: restore.
      if (!diff[XLEN]) begin
        acc_d = {{XLEN{1'b0}}, diff[XLEN-1:0]};
        aux_d = {aux_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {{XLEN{1'b0}}, rshift[XLEN-1:0]};
        aux_d = {aux_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = acc_q + (aux_q[0] ? sh_q : '0);
      sh_d  = {sh_q[2*XLEN-2:0], 1'b0};
      aux_d = {1'b0, aux_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      sh_q     <= '0;
      aux_q    <= '0;
    end else if (start) begin
      cnt_q    <= word ? CntWidth'(WordW) : CntWidth'(XLEN);
      is_div_q <= is_div;
      acc_q    <= '0;
      if (is_div) begin
        sh_q  <= {{XLEN{1'b0}}, b};
        // Word divides run 32 steps, so the dividend is pre-aligned to the top.
        aux_q <= word ? {a[WordW-1:0], {(XLEN-WordW){1'b0}}} : a;
      end else begin
        sh_q  <= {{XLEN{1'b0}}, a};
        aux_q <= b;
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntWidth'(1);
      acc_q <= acc_d;
      sh_q  <= sh_d;
      aux_q <= aux_d;
    end
  end

  assign last      = (cnt_q == CntWidth'(1));
  assign prod_next = acc_d;
  assign quot_next = aux_d;
  assign rem_next  = acc_d[XLEN-1:0];

endmodule

// File: rtl/ysyx_22040088_mdu.sv
// Iterative multiply/divide unit for the RV64 execute stage.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   flush                    : abort any in-flight operation, drop the result
//   in_valid / in_ready      : request handshake (ready only in IDLE)
//   op                       : MDU_MUL / MDU_DIV / MDU_REM (3 behaves as MUL)
//   src1_signed, src2_signed : operand signedness
//   mul_hi                   : upper half of the product (64-bit MUL only)
//   word                     : *W variant, 32-bit operands, sign-extended result
//   src1, src2               : operands
//   out_valid / out_ready    : result handshake
//   result                   : result, held stable while out_valid
module ysyx_22040088_mdu #(
  parameter int unsigned XLEN = ysyx_22040088_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            src1_signed,
  input  logic            src2_signed,
  input  logic            mul_hi,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  import ysyx_22040088_pkg::*;

  localparam int unsigned WordW = 32;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{(XLEN-WordW){v[WordW-1]}}, v[WordW-1:0]};
  endfunction

  mdu_state_t state_q;
  logic       is_div_q, is_rem_q, mul_hi_q, word_q, neg_q;

  logic [XLEN-1:0] op1, op2, mag1, mag2, min_neg, spec_res;
  logic            neg1, neg2, is_divrem, res_neg, div_zero, div_ovf, special;

  logic              iter_start, iter_last;
  logic [2*XLEN-1:0] prod_next, prod_s;
  logic [XLEN-1:0]   quot_next, rem_next, quot_s, rem_s, calc_res;

  // Operand reduction, magnitudes and special-case detection on the incoming request.
  always_comb begin
    op1 = src1;
    op2 = src2;
    if (word) begin
      op1 = src1_signed ? sext_word(src1) : {{(XLEN-WordW){1'b0}}, src1[WordW-1:0]};
      op2 = src2_signed ? sext_word(src2) : {{(XLEN-WordW){1'b0}}, src2[WordW-1:0]};
    end
    neg1 = src1_signed & op1[XLEN-1];
    neg2 = src2_signed & op2[XLEN-1];
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    mag1 = neg1 ? -op1 : op1;
    mag2 = neg2 ? -op2 : op2;

    is_divrem = (op == MDU_DIV) || (op == MDU_REM);
    res_neg   = (op == MDU_REM) ? neg1 : (neg1 ^ neg2);

    min_neg  = word ? {{(XLEN-WordW+1){1'b1}}, {(WordW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_divrem && (op2 == '0);
    div_ovf  = is_divrem && src1_signed && src2_signed && (op1 == min_neg) && (op2 == '1);
    special  = div_zero || div_ovf;

    if (div_zero) begin
      spec_res = (op == MDU_REM) ? op1 : '1;
    end else begin
      spec_res = (op == MDU_REM) ? '0 : op1;
    end
    if (word) begin
      spec_res = sext_word(spec_res);
    end
  end

  // Final sign correction and selection, evaluated on the step that ends CALC.
  always_comb begin
    prod_s = neg_q ? -prod_next : prod_next;
    quot_s = neg_q ? -quot_next : quot_next;
    rem_s  = neg_q ? -rem_next : rem_next;
    if (is_rem_q) begin
      calc_res = rem_s;
    end else if (is_div_q) begin
      calc_res = quot_s;
    end else if (mul_hi_q && !word_q) begin
      calc_res = prod_s[2*XLEN-1:XLEN];
    end else begin
      calc_res = prod_s[XLEN-1:0];
    end
    if (word_q) begin
      calc_res = sext_word(calc_res);
    end
  end

  assign iter_start = (state_q == StIdle) && in_valid && !special && !flush;

  ysyx_22040088_mdu_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .start     (iter_start),
    .is_div    (is_divrem),
    .word      (word),
    .a         (mag1),
    .b         (mag2),
    .last      (iter_last),
    .prod_next (prod_next),
    .quot_next (quot_next),
    .rem_next  (rem_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      is_div_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      mul_hi_q  <= 1'b0;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
    end else if (flush) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            is_div_q <= (op == MDU_DIV);
            is_rem_q <= (op == MDU_REM);
            mul_hi_q <= mul_hi;
            word_q   <= word;
            neg_q    <= res_neg;
            in_ready <= 1'b0;
            if (special) begin
              state_q   <= StDone;
              out_valid <= 1'b1;
              result    <= spec_res;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (iter_last) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
            result    <= calc_res;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_22040088_mdu.md
# ysyx_22040088_mdu

- Iterative multiply/divide unit for the RV64 NPC execute stage.
- Sits directly downstream of the control unit. It consumes the decoded mul/div/rem operation class, operand signedness and word-mode flag, plus the two register operands, selected from `rdata1`/`rdata2` by the control unit's source selects.
- Produces one 64-bit result through a valid/ready handshake. The pipeline stalls on `in_ready`/`out_valid`.

## Interface
Parameters:
- `XLEN`, 64: operand and result width.

Ports:
- `clk` in 1: clock. The block uses this single clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: abort any in-flight operation.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request. High only in IDLE.
- `op` in 2: operation select. `MDU_MUL`=0, `MDU_DIV`=1, `MDU_REM`=2. Value 3 is treated as MUL.
- `src1_signed` in 1: treat `src1` as two's complement.
- `src2_signed` in 1: treat `src2` as two's complement.
- `mul_hi` in 1: return the upper XLEN bits of the product. Ignored when `word`=1 or `op`≠MUL.
- `word` in 1: *W variant.
- `src1` in XLEN: first operand.
- `src2` in XLEN: second operand.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out XLEN: result value.

## Operation
The FSM has three states: IDLE, CALC, DONE.

**Accept**
- A request is accepted when `in_valid`&`in_ready`; operands, op and flags are latched.
- In word mode, operands are first reduced to bits [31:0]:
  - signed operand: sign-extended;
  - unsigned operand: zero-extended.
- The engine then works on the magnitudes |src1| and |src2|. The result sign is recorded:
  - MUL: sign(src1) XOR sign(src2);
  - DIV: sign(src1) XOR sign(src2);
  - REM: sign(src1).

**Special cases (DIV/REM only)** — these go IDLE→DONE directly:
- Divide by zero: quotient = all ones; remainder = dividend (after word reduction).
- Signed overflow, i.e. most-negative ÷ -1 (64-bit, or 32-bit in word mode): quotient = dividend; remainder = 0.

**CALC**
- Iteration count N = 64, or 32 when `word`.
- A counter is loaded with N and decremented each cycle.
- MUL: shift-add, one multiplier bit per cycle, 128-bit accumulator.
- DIV/REM: restoring division, one quotient bit per cycle.
- When the counter reaches 1, the state moves to DONE. On that same edge the 2's-complement sign correction is applied and the result is registered.

**Result selection**
- MUL: low half, or high half if `mul_hi`.
- DIV: quotient.
- REM: remainder.
- Word mode: the result is bits [31:0] sign-extended to 64 bits, for every op including divuw/remuw.

**DONE**
- `out_valid`=1 and `result` is held stable.
- On `out_valid`&`out_ready` the state returns to IDLE.
- `in_ready` goes high on the next cycle; there is no back-to-back bypass.

**Flush**
- In any state, `flush`=1 forces IDLE at the next edge and discards the result.
- `flush` takes priority over acceptance and over `out_ready`.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, counter 0.
- Accept at edge T0:
  - the unit is in CALC from T0 through T0+N-1;
  - `out_valid` rises at T0+N.
- Latency is therefore 64 cycles for 64-bit ops and 32 cycles for word ops.
- Special-case DIV/REM: `out_valid` is high the cycle after acceptance (latency 1).
- `in_ready` is 0 in CALC and DONE. Requests presented then are ignored and do not stall the FSM.
- `out_ready` low in DONE: the unit holds indefinitely.
- `rst` mid-operation: same effect as reset. No partial result escapes.
- Simultaneous `flush` and accept in IDLE: the request is dropped and the unit stays in IDLE.

## Structure
- Shared package `ysyx_22040088_pkg` holds:
  - `XLEN`;
  - op encodings `MDU_MUL`/`MDU_DIV`/`MDU_REM`;
  - FSM state typedef `mdu_state_t`.
- One sub-module, `ysyx_22040088_mdu_iter`: the unsigned iterative engine (accumulator, shift register, counter, single step per cycle).
- The outer block owns:
  - handshake and FSM;
  - word reduction;
  - sign/magnitude conversion;
  - special-case detection;
  - final result selection.

## Test plan
- MUL: 6×7 with `word`=0, unsigned → 42. `out_valid` exactly 64 cycles after accept.
- MULH signed, with src1=src2=0x8000_0000_0000_0000 → 0x4000_0000_0000_0000.
- MULHSU: src1=-1, src2=2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV signed: -7÷2 → -3. REM signed: -7÷2 → -1.
- DIVW: 0x8000_0000 ÷ 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 with latency 1. DIVUW: 0xFFFF_FFFE ÷ 1 → 0xFFFF_FFFF_FFFF_FFFE after 32 cycles.
- Divide by zero:
  - DIV 5÷0 → all ones;
  - REMU 5÷0 → 5;
  - REMW 0x1_0000_0005 ÷ 0 → 5.
- Handshake and control:
  - hold `out_ready`=0 for 10 cycles in DONE → `result` stable, `in_ready`=0;
  - assert `flush` at CALC cycle 20 → IDLE next cycle and no `out_valid`;
  - pulse `rst` mid-CALC → all outputs return to their reset values.
